// File: rtl/mask_rev_reader.sv
// Host-side reader for the indexed mask-revision nibble display: steps idx_out 0..7, samples nibble_in, assembles word.
// Optional double-pass consistency check enabled by defining MASK_REV_READER_CHECK_EN.
module mask_rev_reader #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [2:0]  idx_out,
  input  logic [3:0]  nibble_in,
  output logic        err
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SLOT_W = 5;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    settle_cnt;
  logic [WORD_W-1:0]   shadow;
  logic [SLOT_W-1:0]   slot_c;
  logic [WORD_W-1:0]   shadow_upd_c;

  // Bit offset of the current index's nibble inside the assembled word.
  assign slot_c = MSB_FIRST ? (SLOT_W'(28) - {idx_out, 2'b00}) : {idx_out, 2'b00};

  always_comb begin
    shadow_upd_c = shadow;
    shadow_upd_c[slot_c +: NIB_W] = nibble_in;
  end

`ifdef MASK_REV_READER_CHECK_EN
  logic             verify_pass;
  logic [NIB_W-1:0] shadow_nib_c;

  assign shadow_nib_c = shadow[slot_c +: NIB_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      shadow     <= '0;
      idx_out    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef MASK_REV_READER_CHECK_EN
      verify_pass <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            idx_out    <= '0;
            busy       <= 1'b1;
            word_valid <= 1'b0;
            err        <= 1'b0;
            settle_cnt <= '0;
`ifdef MASK_REV_READER_CHECK_EN
            verify_pass <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state      <= SAMPLE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        SAMPLE: begin
`ifdef MASK_REV_READER_CHECK_EN
          // Second pass only compares; shadow keeps first-pass data.
          if (verify_pass) begin
            if (nibble_in != shadow_nib_c) err <= 1'b1;
          end else begin
            shadow <= shadow_upd_c;
          end
          if (idx_out != IDX_W'(7)) begin
            idx_out <= idx_out + IDX_W'(1);
            state   <= SETTLE;
          end else begin
            idx_out <= '0;
            if (!verify_pass) begin
              verify_pass <= 1'b1;
              state       <= SETTLE;
            end else begin
              state      <= DONE;
              word       <= shadow;
              word_valid <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
            end
          end
`else
          shadow <= shadow_upd_c;
          if (idx_out != IDX_W'(7)) begin
            idx_out <= idx_out + IDX_W'(1);
            state   <= SETTLE;
          end else begin
            idx_out    <= '0;
            state      <= DONE;
            word       <= shadow_upd_c;
            word_valid <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_rev_reader.sv
// Directed bench for mask_rev_reader: LSB-first and MSB-first instances share clk/rst/start.
module tb_mask_rev_reader;

  localparam int unsigned SC   = 2;
  localparam int          STEP = SC + 1;
`ifdef MASK_REV_READER_CHECK_EN
  localparam int          LAT  = 16 * STEP;
`else
  localparam int          LAT  = 8 * STEP;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flip;
  logic [31:0] rev0 = 32'h1234_ABCD;
  logic [31:0] rev1 = 32'hDEAD_BEEF;

  logic        busy0, done0, wv0, err0, busy1, done1, wv1, err1;
  logic [31:0] word0, word1;
  logic [2:0]  idx0, idx1;
  logic [3:0]  nib0, nib1;

  int total = 0;
  int bad   = 0;
  int dones;
  int done_at;

  // Display models; flip corrupts index 3 to exercise the verify pass.
  assign nib0 = rev0[4*idx0 +: 4] ^ ((flip && idx0 == 3'd3) ? 4'hF : 4'h0);
  assign nib1 = rev1[31-4*idx1 -: 4];

  mask_rev_reader #(.SETTLE_CYCLES(SC), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .word_valid(wv0), .word(word0), .idx_out(idx0), .nibble_in(nib0), .err(err0)
  );

  mask_rev_reader #(.SETTLE_CYCLES(SC), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .word_valid(wv1), .word(word1), .idx_out(idx1), .nibble_in(nib1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller raises start; this accepts it and checks the full read.
  task automatic read_check(input string tag, input int flip_from, input logic exp_err);
    tick();
    start = 1'b0;
    chk({tag, "_wv_clr"}, 32'(wv0), 32'd0);
    chk({tag, "_err_clr"}, 32'(err0), 32'd0);
    for (int n = 0; n < LAT; n++) begin
      if (n > 0) tick();
      if (n == flip_from) flip = 1'b1;
      chk({tag, "_idx"}, 32'(idx0), 32'((n / STEP) % 8));
      chk({tag, "_busy"}, 32'(busy0), 32'd1);
      chk({tag, "_nodone"}, 32'(done0), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(done0), 32'd1);
    chk({tag, "_done_msb"}, 32'(done1), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy0), 32'd0);
    chk({tag, "_wv"}, 32'(wv0), 32'd1);
    chk({tag, "_word"}, word0, 32'h1234_ABCD);
    chk({tag, "_word_msb"}, word1, 32'hDEAD_BEEF);
    chk({tag, "_err"}, 32'(err0), 32'(exp_err));
    chk({tag, "_idx_wrap"}, 32'(idx0), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done0), 32'd0);
    chk({tag, "_wv_hold"}, 32'(wv0), 32'd1);
    chk({tag, "_err_hold"}, 32'(err0), 32'(exp_err));
    flip = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    flip  = 1'b0;
    tick();
    tick();
    rst   = 1'b0;

    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0 || done1) dones++;
    end
    chk("idle_no_done", 32'(dones), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_wv", 32'(wv0), 32'd0);
    chk("rst_word", word0, 32'd0);
    chk("rst_word_msb", word1, 32'd0);
    chk("rst_idx", 32'(idx0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);

    start = 1'b1;
    read_check("rd1", -1, 1'b0);

    // Start pulsed mid-read and held through DONE: ignored until IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    done_at = -1;
    for (int n = 1; n <= LAT + 1; n++) begin
      if (n == 5) start = 1'b1;
      else if (n == 6) start = 1'b0;
      if (n == LAT + 1) start = 1'b1;
      tick();
      if (done0) begin
        dones++;
        done_at = n;
      end
    end
    chk("ign_done_cnt", 32'(dones), 32'd1);
    chk("ign_done_at", 32'(done_at), 32'(LAT));
    chk("ign_idle_busy", 32'(busy0), 32'd0);
    chk("ign_idle_wv", 32'(wv0), 32'd1);
    tick();
    chk("rearm_busy", 32'(busy0), 32'd1);
    chk("rearm_wv", 32'(wv0), 32'd0);
    start = 1'b0;
    dones = 0;
    for (int n = 1; n <= LAT + 2; n++) begin
      tick();
      if (done0) dones++;
    end
    chk("rearm_done_cnt", 32'(dones), 32'd1);
    chk("rearm_word", word0, 32'h1234_ABCD);

    // Reset mid-read aborts without a done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_word", word0, 32'd0);
    chk("abort_wv", 32'(wv0), 32'd0);
    chk("abort_idx", 32'(idx0), 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < LAT + 5; n++) begin
      tick();
      if (done0) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_idle_busy", 32'(busy0), 32'd0);

`ifdef MASK_REV_READER_CHECK_EN
    start = 1'b1;
    read_check("verify_bad", 8 * STEP, 1'b1);
    start = 1'b1;
    read_check("verify_clean", -1, 1'b0);
`else
    start = 1'b1;
    read_check("rd2", -1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
